// File: rtl/ram_resp_pkg.sv
// Shared widths and the store-buffer entry layout for the data-RAM response block.
package ram_resp_pkg;

    localparam int XLEN_DEF     = 64;
    localparam int SB_DEPTH_DEF = 4;
    localparam int BE_W         = 8;

    // Address keeps only the doubleword index; the low three bits are always zero.
    typedef struct packed {
        logic [XLEN_DEF-4:0] addr;
        logic [BE_W-1:0]     be;
        logic [XLEN_DEF-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/ram_resp_if.sv
// Mem-stage request/response and backing-SRAM port bundle for ram_resp.
interface ram_resp_if
    import ram_resp_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);

    logic [XLEN-1:0] ram_addr_i;
    logic            ram_wen_i;
    logic [BE_W-1:0] ram_byte_en_i;
    logic [XLEN-1:0] ram_wdata_i;
    logic            ram_ren_i;
    logic [XLEN-1:0] ram_rdata_o;
    logic            ram_stall_o;
    logic            sb_empty_o;
    logic [XLEN-1:0] bk_raddr_o;
    logic [XLEN-1:0] bk_rdata_i;
    logic            bk_wvalid_o;
    logic            bk_wready_i;
    logic [XLEN-1:0] bk_waddr_o;
    logic [BE_W-1:0] bk_wbe_o;
    logic [XLEN-1:0] bk_wdata_o;

    modport slave (
        input  ram_addr_i, ram_wen_i, ram_byte_en_i, ram_wdata_i, ram_ren_i,
               bk_rdata_i, bk_wready_i,
        output ram_rdata_o, ram_stall_o, sb_empty_o, bk_raddr_o,
               bk_wvalid_o, bk_waddr_o, bk_wbe_o, bk_wdata_o
    );

    modport master (
        output ram_addr_i, ram_wen_i, ram_byte_en_i, ram_wdata_i, ram_ren_i,
               bk_rdata_i, bk_wready_i,
        input  ram_rdata_o, ram_stall_o, sb_empty_o, bk_raddr_o,
               bk_wvalid_o, bk_waddr_o, bk_wbe_o, bk_wdata_o
    );

endinterface

// File: rtl/sb_fwd_merge.sv
// Per-byte overlay of pending store-buffer entries onto backing read data.
module sb_fwd_merge
    import ram_resp_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEF
) (
    input  logic [XLEN_DEF-4:0]        addr,
    input  logic [XLEN_DEF-1:0]        base,
    input  sb_entry_t [SB_DEPTH-1:0]   entries,
    input  logic [SB_DEPTH-1:0]        valid,
    output logic [XLEN_DEF-1:0]        merged
);

    // Index 0 is the oldest entry, so later iterations let younger stores win.
    always_comb begin
        merged = base;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (valid[i] && (entries[i].addr == addr)) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (entries[i].be[b]) begin
                        merged[8*b +: 8] = entries[i].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ram_resp.sv
// Store buffer in front of the data SRAM: queues stores, drains them in order,
// and forwards pending store bytes to loads with zero latency.
module ram_resp
    import ram_resp_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEF,
    parameter int XLEN     = XLEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    ram_resp_if.slave  bus
);

    localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SB_DEPTH);

    sb_entry_t               mem [SB_DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CNT_W-1:0]        count;
    logic                    full;
    logic                    enq;
    logic                    deq;
    sb_entry_t [SB_DEPTH-1:0] ordered;
    logic [SB_DEPTH-1:0]     ord_valid;
    logic [XLEN-1:0]         merged;

    assign full = (count == FULL);
    // A full buffer refuses the store even if the head retires this same cycle.
    assign enq  = bus.ram_wen_i & ~full;
    assign deq  = bus.bk_wvalid_o & bus.bk_wready_i;

    assign bus.ram_stall_o = bus.ram_wen_i & full;
    assign bus.bk_wvalid_o = (count != '0);
    assign bus.sb_empty_o  = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (deq) head <= head + 1'b1;
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= '{addr: bus.ram_addr_i[XLEN-1:3],
                           be:   bus.ram_byte_en_i,
                           data: bus.ram_wdata_i};
        end
    end

    assign bus.bk_waddr_o = {mem[head].addr, 3'b000};
    assign bus.bk_wbe_o   = mem[head].be;
    assign bus.bk_wdata_o = mem[head].data;

    // Present entries oldest-first so the merge needs no knowledge of the pointers.
    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            ordered[i]   = mem[head + PTR_W'(i)];
            ord_valid[i] = (CNT_W'(i) < count);
        end
    end

    sb_fwd_merge #(
        .SB_DEPTH (SB_DEPTH)
    ) u_merge (
        .addr    (bus.ram_addr_i[XLEN-1:3]),
        .base    (bus.bk_rdata_i),
        .entries (ordered),
        .valid   (ord_valid),
        .merged  (merged)
    );

    assign bus.bk_raddr_o  = bus.ram_ren_i ? (bus.ram_addr_i & ~XLEN'(7)) : '0;
    assign bus.ram_rdata_o = bus.ram_ren_i ? merged : '0;

endmodule

// File: tb/tb_ram_resp.sv
// Scoreboard bench for ram_resp: stimulus queues expected loads and SRAM writes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ram_resp;
    import ram_resp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_resp_if #(.XLEN(64)) bus ();

    ram_resp #(
        .SB_DEPTH (4),
        .XLEN     (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
    } wr_t;

    wr_t         wr_q [$];
    logic [63:0] ld_q [$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_ren_i) begin
                if (ld_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL load_unexpected: got %h expected no load", bus.ram_rdata_o);
                end else begin
                    chk("load_data", bus.ram_rdata_o, ld_q.pop_front());
                end
            end
            if (bus.bk_wvalid_o && bus.bk_wready_i) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_unexpected: got addr %h expected no write", bus.bk_waddr_o);
                end else begin
                    mon_e = wr_q.pop_front();
                    chk("bk_waddr", bus.bk_waddr_o, mon_e.addr);
                    chk("bk_wbe", 64'(bus.bk_wbe_o), 64'(mon_e.be));
                    chk("bk_wdata", bus.bk_wdata_o, mon_e.data);
                end
            end
        end
    end

    task automatic clear_req();
        bus.ram_wen_i = 1'b0;
        bus.ram_ren_i = 1'b0;
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
        clear_req();
    endtask

    task automatic to_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [63:0] a, input logic [7:0] be,
                               input logic [63:0] d, input bit accept);
        wr_t e;
        bus.ram_wen_i     = 1'b1;
        bus.ram_addr_i    = a;
        bus.ram_byte_en_i = be;
        bus.ram_wdata_i   = d;
        if (accept) begin
            e.addr = a;
            e.be   = be;
            e.data = d;
            wr_q.push_back(e);
        end
    endtask

    task automatic drive_load(input logic [63:0] a, input logic [63:0] bk,
                              input logic [63:0] exp);
        bus.ram_ren_i  = 1'b1;
        bus.ram_addr_i = a;
        bus.bk_rdata_i = bk;
        ld_q.push_back(exp);
    endtask

    task automatic wait_empty(input int max);
        int n = 0;
        while (bus.sb_empty_o !== 1'b1 && n < max) begin
            to_pos();
            n++;
        end
        chk("drain_empty", 64'(bus.sb_empty_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_req();
        bus.ram_addr_i    = '0;
        bus.ram_byte_en_i = '0;
        bus.ram_wdata_i   = '0;
        bus.bk_rdata_i    = '0;
        bus.bk_wready_i   = 1'b0;

        // Reset state, including a store request presented during reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sb_empty", 64'(bus.sb_empty_o), 64'd1);
        chk("rst_wvalid", 64'(bus.bk_wvalid_o), 64'd0);
        bus.ram_wen_i     = 1'b1;
        bus.ram_byte_en_i = 8'hFF;
        #1;
        chk("rst_stall", 64'(bus.ram_stall_o), 64'd0);
        bus.ram_wen_i = 1'b0;
        #1;
        rst = 1'b0;
        to_pos();

        // Partial store forwarded over backing data on the next cycle.
        drive_store(64'h100, 8'h0F, 64'h11223344_55667788, 1'b1);
        to_neg();
        chk("empty_before_enq", 64'(bus.sb_empty_o), 64'd1);
        to_pos();
        drive_load(64'h100, 64'hAAAAAAAA_AAAAAAAA, 64'hAAAAAAAA_55667788);
        to_neg();
        chk("bk_raddr", bus.bk_raddr_o, 64'h100);
        chk("sb_not_empty", 64'(bus.sb_empty_o), 64'd0);
        chk("wvalid_pending", 64'(bus.bk_wvalid_o), 64'd1);
        chk("head_waddr", bus.bk_waddr_o, 64'h100);
        to_pos();

        // Same-cycle store is invisible to the load; visible one cycle later.
        drive_store(64'h100, 8'hF0, 64'h99999999_99999999, 1'b1);
        drive_load(64'h100, 64'h0, 64'h00000000_55667788);
        to_pos();
        drive_load(64'h100, 64'h0, 64'h99999999_55667788);
        to_pos();

        // Youngest matching store wins per byte.
        drive_store(64'h200, 8'hFF, 64'h01234567_89ABCDEF, 1'b1);
        to_pos();
        drive_store(64'h200, 8'h01, 64'h00000000_000000EE, 1'b1);
        to_pos();
        drive_load(64'h200, 64'hFFFFFFFF_FFFFFFFF, 64'h01234567_89ABCDEE);
        to_pos();
        to_neg();
        chk("idle_rdata", bus.ram_rdata_o, 64'h0);
        chk("idle_raddr", bus.bk_raddr_o, 64'h0);
        to_pos();

        // Full buffer stalls until the backing port drains the head.
        drive_store(64'h300, 8'hFF, 64'h55555555_55555555, 1'b0);
        to_neg();
        chk("full_stall", 64'(bus.ram_stall_o), 64'd1);
        to_pos();
        drive_store(64'h300, 8'hFF, 64'h55555555_55555555, 1'b0);
        bus.bk_wready_i = 1'b1;
        to_neg();
        chk("full_stall_hold", 64'(bus.ram_stall_o), 64'd1);
        to_pos();
        drive_store(64'h300, 8'hFF, 64'h55555555_55555555, 1'b1);
        to_neg();
        chk("stall_released", 64'(bus.ram_stall_o), 64'd0);
        to_pos();
        wait_empty(12);
        drive_load(64'h100, 64'h00000000_00001234, 64'h00000000_00001234);
        to_pos();

        // Head payload holds while the backing port is not ready.
        bus.bk_wready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_store(64'(8 * i), 8'hFF, 64'hD0D00000_00000000 + 64'(i), 1'b1);
            to_pos();
        end
        for (int i = 0; i < 3; i++) begin
            to_neg();
            chk("hold_waddr", bus.bk_waddr_o, 64'h0);
            chk("hold_wbe", 64'(bus.bk_wbe_o), 64'hFF);
            chk("hold_wdata", bus.bk_wdata_o, 64'hD0D00000_00000000);
            to_pos();
        end
        bus.bk_wready_i = 1'b1;
        wait_empty(10);

        // Asynchronous reset discards pending entries.
        bus.bk_wready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(64'(8 * i), 8'hFF, 64'hE0E00000_00000000 + 64'(i), 1'b0);
            to_pos();
        end
        chk("pre_rst_wvalid", 64'(bus.bk_wvalid_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_wvalid", 64'(bus.bk_wvalid_o), 64'd0);
        chk("async_rst_empty", 64'(bus.sb_empty_o), 64'd1);
        to_pos();
        to_pos();
        rst = 1'b0;
        drive_load(64'h0, 64'hCAFEBABE_DEADBEEF, 64'hCAFEBABE_DEADBEEF);
        to_pos();

        // Back-to-back store and drain wraps the pointers.
        bus.bk_wready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_store(64'h1000 + 64'(8 * i), 8'h81 | (8'h01 << (i % 8)),
                        {32'hB0B0B0B0, 32'(i)}, 1'b1);
            to_neg();
            chk("stream_stall", 64'(bus.ram_stall_o), 64'd0);
            to_pos();
        end
        wait_empty(10);
        to_pos();

        chk("loads_all_seen", 64'(ld_q.size()), 64'd0);
        chk("writes_all_seen", 64'(wr_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
